// File: rtl/eth_mac_tx_gmii_8.sv
// eth_mac_tx_gmii_8: 8-bit Ethernet MAC transmit stage, AXI-stream frame bytes in, GMII out.
// Adds preamble/SFD, CRC-32 FCS and inter-frame gap, and flags underflow/bad beats on tx_er.
// Build option: define ETH_MAC_TX_MIN_FRAME_PAD_EN to pad short frames up to MIN_FRAME_LEN.

module eth_mac_tx_gmii_8 #(
    parameter int unsigned MIN_FRAME_LEN = 60,
    parameter int unsigned MIN_IFG       = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    input  logic [7:0] ifg_delay,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       start_packet,
    output logic       error_underflow
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StPreamble = 3'd1;
    localparam logic [2:0] StPayload  = 3'd2;
    localparam logic [2:0] StWaitLast = 3'd3;
    localparam logic [2:0] StFcs      = 3'd4;
    localparam logic [2:0] StIfg      = 3'd5;
`ifdef ETH_MAC_TX_MIN_FRAME_PAD_EN
    localparam logic [2:0] StPad      = 3'd6;
    localparam logic [5:0] MinLen     = 6'(MIN_FRAME_LEN);
`endif

    localparam logic [31:0] CrcPoly = 32'hEDB88320;
    localparam logic [7:0]  MinIfg  = 8'(MIN_IFG);

    // Byte counter is 6 bits and the gap counter 8 bits; reject parameters that do not fit.
    if (MIN_FRAME_LEN > 63 || MIN_IFG < 1 || MIN_IFG > 255) begin : g_param_check
        $error("eth_mac_tx_gmii_8: MIN_FRAME_LEN or MIN_IFG out of range");
    end

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
        end
        return c;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [2:0]  phase_q, phase_d;     // preamble byte index, then FCS byte index
    logic [31:0] crc_q, crc_d;
    logic [7:0]  ifg_cnt_q, ifg_cnt_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic        start_q, start_d;
    logic        underflow_q, underflow_d;
    logic [7:0]  ifg_load;
    logic [31:0] fcs;
`ifdef ETH_MAC_TX_MIN_FRAME_PAD_EN
    logic [5:0]  byte_cnt_q, byte_cnt_d, byte_cnt_inc;

    assign byte_cnt_inc = (byte_cnt_q >= MinLen) ? byte_cnt_q : byte_cnt_q + 6'd1;
`endif

    assign s_axis_tready = (state_q == StPayload) || (state_q == StWaitLast);
    // Outputs are registered, so the IFG state lasts one cycle less than the wire gap and the
    // IDLE cycle before the next preamble supplies the final idle byte.
    assign ifg_load = ((ifg_delay > MinIfg) ? ifg_delay : MinIfg) - 8'd1;
    assign fcs      = ~crc_q;

    assign gmii_txd        = txd_q;
    assign gmii_tx_en      = tx_en_q;
    assign gmii_tx_er      = tx_er_q;
    assign start_packet    = start_q;
    assign error_underflow = underflow_q;

    // Next-state, CRC, counters and next GMII byte
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        crc_d       = crc_q;
        ifg_cnt_d   = ifg_cnt_q;
        txd_d       = 8'h00;
        tx_en_d     = 1'b0;
        tx_er_d     = 1'b0;
        start_d     = 1'b0;
        underflow_d = 1'b0;
`ifdef ETH_MAC_TX_MIN_FRAME_PAD_EN
        byte_cnt_d  = byte_cnt_q;
`endif
        case (state_q)
            StIdle: begin
                if (s_axis_tvalid) begin
                    state_d = StPreamble;
                    phase_d = 3'd0;
                end
            end
            StPreamble: begin
                tx_en_d = 1'b1;
                txd_d   = (phase_q == 3'd7) ? 8'hD5 : 8'h55;
                start_d = (phase_q == 3'd0);
                crc_d   = 32'hFFFF_FFFF;
`ifdef ETH_MAC_TX_MIN_FRAME_PAD_EN
                byte_cnt_d = 6'd0;
`endif
                phase_d = phase_q + 3'd1;
                if (phase_q == 3'd7) begin
                    state_d = StPayload;
                end
            end
            StPayload: begin
                tx_en_d = 1'b1;
                if (s_axis_tvalid) begin
                    txd_d   = s_axis_tdata;
                    tx_er_d = s_axis_tuser;
                    crc_d   = crc_byte(crc_q, s_axis_tdata);
`ifdef ETH_MAC_TX_MIN_FRAME_PAD_EN
                    byte_cnt_d = byte_cnt_inc;
`endif
                    if (s_axis_tlast) begin
                        phase_d = 3'd0;
                        state_d = StFcs;
`ifdef ETH_MAC_TX_MIN_FRAME_PAD_EN
                        if (byte_cnt_inc < MinLen) begin
                            state_d = StPad;
                        end
`endif
                    end
                end else begin
                    // Upstream starved mid-frame: poison the frame and drop the rest of it.
                    tx_er_d     = 1'b1;
                    underflow_d = 1'b1;
                    state_d     = StWaitLast;
                end
            end
            StWaitLast: begin
                // Gap is measured from the discarded tail, so it is never shorter than asked.
                if (s_axis_tvalid && s_axis_tlast) begin
                    ifg_cnt_d = ifg_load;
                    state_d   = StIfg;
                end
            end
`ifdef ETH_MAC_TX_MIN_FRAME_PAD_EN
            StPad: begin
                tx_en_d    = 1'b1;
                crc_d      = crc_byte(crc_q, 8'h00);
                byte_cnt_d = byte_cnt_q + 6'd1;
                if (byte_cnt_q + 6'd1 == MinLen) begin
                    phase_d = 3'd0;
                    state_d = StFcs;
                end
            end
`endif
            StFcs: begin
                tx_en_d = 1'b1;
                case (phase_q[1:0])
                    2'd0:    txd_d = fcs[7:0];
                    2'd1:    txd_d = fcs[15:8];
                    2'd2:    txd_d = fcs[23:16];
                    default: txd_d = fcs[31:24];
                endcase
                phase_d = phase_q + 3'd1;
                if (phase_q[1:0] == 2'd3) begin
                    ifg_cnt_d = ifg_load;
                    state_d   = StIfg;
                end
            end
            StIfg: begin
                ifg_cnt_d = ifg_cnt_q - 8'd1;
                if (ifg_cnt_q <= 8'd1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, CRC and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            phase_q    <= 3'd0;
            crc_q      <= 32'hFFFF_FFFF;
            ifg_cnt_q  <= 8'd0;
`ifdef ETH_MAC_TX_MIN_FRAME_PAD_EN
            byte_cnt_q <= 6'd0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            crc_q      <= crc_d;
            ifg_cnt_q  <= ifg_cnt_d;
`ifdef ETH_MAC_TX_MIN_FRAME_PAD_EN
            byte_cnt_q <= byte_cnt_d;
`endif
        end
    end

    // Registered GMII byte, enables and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txd_q       <= 8'h00;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            start_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            txd_q       <= txd_d;
            tx_en_q     <= tx_en_d;
            tx_er_q     <= tx_er_d;
            start_q     <= start_d;
            underflow_q <= underflow_d;
        end
    end

endmodule
